// File: rtl/f_pc_unit.sv
// rtl/f_pc_unit.sv - fetch-stage program counter and next-PC selection
//
// Holds the F-stage PC register and selects the next fetch address from
// sequential PC+4, a taken D-stage branch, a j/jal absolute target or a
// jr/jalr register target. Redirects decided in D take effect on the fetch
// after the delay slot; a stall holds the PC and the hazard unit keeps the
// D-stage inputs frozen, so the redirect is applied on the first free edge.
//
// Optional feature macro: FPC_ADEL_CHECK_EN
//   defined     -> F_exc_adel flags a misaligned or out-of-text fetch address
//   not defined -> F_exc_adel is tied low and no comparators are built
//
// Parameters:
//   RESET_PC   PC loaded while reset is asserted
//   TEXT_LO    lowest legal fetch address (address check only)
//   TEXT_HI    highest legal fetch address, inclusive (address check only)
//
// Ports:
//   clk         in   1   rising-edge clock
//   reset       in   1   asynchronous active-low reset
//   F_stall     in   1   1 = hold the PC this cycle
//   D_NPCOp     in   2   next-PC select: 0 PC4, 1 BRANCH, 2 J, 3 JR
//   D_bjump     in   1   branch-taken flag, meaningful only for BRANCH
//   D_PC        in  32   PC of the instruction in D
//   D_imm16     in  16   branch word offset
//   D_imm26     in  26   jump word index
//   D_rs_data   in  32   forwarded rs value for JR
//   F_PC        out 32   registered fetch address
//   F_NPC       out 32   combinational next fetch address
//   F_exc_adel  out  1   fetch address error

module f_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI  = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        F_stall,
    input  logic [1:0]  D_NPCOp,
    input  logic        D_bjump,
    input  logic [31:0] D_PC,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_rs_data,
    output logic [31:0] F_PC,
    output logic [31:0] F_NPC,
    output logic        F_exc_adel
);

    localparam logic [1:0] NPC_PC4    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_J      = 2'd2;
    localparam logic [1:0] NPC_JR     = 2'd3;

    // A text window with its bounds swapped would flag every fetch.
    if (TEXT_HI < TEXT_LO) begin : g_bad_text_range
        $error("f_pc_unit: TEXT_HI below TEXT_LO");
    end

    logic [31:0] pc_reg;
    logic [31:0] seq_pc;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // Branch offset is relative to the delay-slot address (D_PC + 4);
    // every sum wraps modulo 2^32.
    assign seq_pc        = pc_reg + 32'd4;
    assign branch_offset = {{14{D_imm16[15]}}, D_imm16, 2'b00};
    assign branch_target = D_PC + 32'd4 + branch_offset;
    assign jump_target   = {D_PC[31:28], D_imm26, 2'b00};

    always_comb begin
        F_NPC = seq_pc;
        case (D_NPCOp)
            NPC_PC4:    F_NPC = seq_pc;
            NPC_BRANCH: F_NPC = D_bjump ? branch_target : seq_pc;
            NPC_J:      F_NPC = jump_target;
            NPC_JR:     F_NPC = D_rs_data;
            default:    F_NPC = seq_pc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg <= RESET_PC;
        end else if (!F_stall) begin
            pc_reg <= F_NPC;
        end
    end

    assign F_PC = pc_reg;

`ifdef FPC_ADEL_CHECK_EN
    // Flag only; fetch carries on and the exception logic squashes.
    assign F_exc_adel = (pc_reg[1:0] != 2'b00) || (pc_reg < TEXT_LO) || (pc_reg > TEXT_HI);
`else
    assign F_exc_adel = 1'b0;
`endif

endmodule

// File: tb/tb_f_pc_unit.sv
// tb/tb_f_pc_unit.sv - directed and randomized checks of f_pc_unit against a reference model

module tb_f_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] TEXT_LO  = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI  = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        F_stall;
    logic [1:0]  D_NPCOp;
    logic        D_bjump;
    logic [31:0] D_PC;
    logic [15:0] D_imm16;
    logic [25:0] D_imm26;
    logic [31:0] D_rs_data;
    logic [31:0] F_PC;
    logic [31:0] F_NPC;
    logic        F_exc_adel;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_pc;

    f_pc_unit #(
        .RESET_PC (RESET_PC),
        .TEXT_LO  (TEXT_LO),
        .TEXT_HI  (TEXT_HI)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .F_stall    (F_stall),
        .D_NPCOp    (D_NPCOp),
        .D_bjump    (D_bjump),
        .D_PC       (D_PC),
        .D_imm16    (D_imm16),
        .D_imm26    (D_imm26),
        .D_rs_data  (D_rs_data),
        .F_PC       (F_PC),
        .F_NPC      (F_NPC),
        .F_exc_adel (F_exc_adel)
    );

    always #5 clk = ~clk;

    // Next fetch address from the architectural rules, integer arithmetic.
    function automatic logic [31:0] ref_npc(logic [31:0] pc, logic [1:0] op, logic bj,
                                            logic [31:0] dpc, logic [15:0] i16,
                                            logic [25:0] i26, logic [31:0] rs);
        longint off;
        off = longint'($signed(i16)) * 4;
        if (op == 2'd1 && bj) return 32'(longint'(dpc) + 4 + off);
        if (op == 2'd2)       return (dpc & 32'hF000_0000) | 32'(longint'(i26) * 4);
        if (op == 2'd3)       return rs;
        return 32'(longint'(pc) + 4);
    endfunction

    function automatic logic ref_adel(logic [31:0] pc);
`ifdef FPC_ADEL_CHECK_EN
        return (pc % 4 != 0) || (pc < TEXT_LO) || (pc > TEXT_HI);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check F_NPC before the edge and F_PC/F_exc_adel after.
    task automatic cycle(input string tag, input logic [1:0] op, input logic bj,
                         input logic [31:0] dpc, input logic [15:0] i16,
                         input logic [25:0] i26, input logic [31:0] rs, input logic stall);
        logic [31:0] exp_npc;
        D_NPCOp = op; D_bjump = bj; D_PC = dpc; D_imm16 = i16;
        D_imm26 = i26; D_rs_data = rs; F_stall = stall;
        #1;
        exp_npc = ref_npc(model_pc, op, bj, dpc, i16, i26, rs);
        chk32({tag, "_npc"}, F_NPC, exp_npc);
        @(posedge clk);
        #1;
        if (!stall) model_pc = exp_npc;
        chk32({tag, "_pc"}, F_PC, model_pc);
        chk1({tag, "_adel"}, F_exc_adel, ref_adel(model_pc));
    endtask

    task automatic pc4(input string tag);
        cycle(tag, 2'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0);
    endtask

    task automatic jr(input string tag, input logic [31:0] target);
        cycle(tag, 2'd3, 1'b0, 32'h0, 16'h0, 26'h0, target, 1'b0);
    endtask

    initial begin
        reset = 1'b0; F_stall = 1'b0; D_NPCOp = 2'd0; D_bjump = 1'b0;
        D_PC = '0; D_imm16 = '0; D_imm26 = '0; D_rs_data = '0;
        model_pc = RESET_PC;

        repeat (2) @(posedge clk);
        #1;
        chk32("reset_pc", F_PC, 32'h0000_3000);
        chk1("reset_adel", F_exc_adel, 1'b0);
        reset = 1'b1;

        // Mid-cycle asynchronous reset from 3010.
        jr("jr_3010", 32'h0000_3010);
        #2 reset = 1'b0;
        #1;
        model_pc = RESET_PC;
        chk32("async_reset", F_PC, 32'h0000_3000);
        #1 reset = 1'b1;
        pc4("seq1"); chk32("seq1_abs", F_PC, 32'h0000_3004);
        pc4("seq2"); chk32("seq2_abs", F_PC, 32'h0000_3008);
        pc4("seq3"); chk32("seq3_abs", F_PC, 32'h0000_300C);

        // Taken backward branch, then not-taken.
        cycle("br_taken", 2'd1, 1'b1, 32'h0000_3008, 16'hFFFE, 26'h0, 32'h0, 1'b0);
        chk32("br_taken_abs", F_PC, 32'h0000_3004);
        cycle("br_not", 2'd1, 1'b0, 32'h0000_3008, 16'hFFFE, 26'h0, 32'h0, 1'b0);
        chk32("br_not_abs", F_PC, 32'h0000_3008);
        // D_bjump ignored outside BRANCH.
        cycle("bj_ignored", 2'd0, 1'b1, 32'h0000_3008, 16'h0100, 26'h0, 32'h0, 1'b0);
        chk32("bj_ignored_abs", F_PC, 32'h0000_300C);

        cycle("jump", 2'd2, 1'b0, 32'h0000_3010, 16'h0, 26'h0000C40, 32'h0, 1'b0);
        chk32("jump_abs", F_PC, 32'h0000_3100);
        jr("jr", 32'h0000_3204);
        chk32("jr_abs", F_PC, 32'h0000_3204);

        // Stall holds against a taken branch to 3040 held in D.
        cycle("stall1", 2'd1, 1'b1, 32'h0000_3000, 16'h000F, 26'h0, 32'h0, 1'b1);
        cycle("stall2", 2'd1, 1'b1, 32'h0000_3000, 16'h000F, 26'h0, 32'h0, 1'b1);
        chk32("stall_hold_abs", F_PC, 32'h0000_3204);
        cycle("stall_rel", 2'd1, 1'b1, 32'h0000_3000, 16'h000F, 26'h0, 32'h0, 1'b0);
        chk32("stall_rel_abs", F_PC, 32'h0000_3040);

        jr("wrap_jr", 32'hFFFF_FFFC);
        pc4("wrap");
        chk32("wrap_abs", F_PC, 32'h0000_0000);

        jr("adel_misalign", 32'h0000_3002);
        jr("adel_high", 32'h0000_7000);
        jr("adel_top", 32'h0000_6FFC);
        chk1("adel_top_abs", F_exc_adel, 1'b0);

        // Randomized sequence; targets biased toward the text window.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] rdpc, rrs;
            rdpc = 32'h0000_3000 + ($urandom_range(0, 32'h3FFF) & 32'hFFFF_FFFC);
            if ($urandom_range(0, 7) == 0) rdpc = $urandom;
            rrs = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                              : 32'h0000_2FF0 + 32'($urandom_range(0, 32'h4020));
            cycle("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rdpc,
                  16'($urandom), 26'($urandom), rrs, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/f_pc_unit.md
# f_pc_unit

Fetch-stage program-counter unit for the five-stage MIPS pipeline. It holds the F-stage PC register and computes the next fetch address. Sources are sequential PC+4, a taken conditional branch resolved by the D-stage comparator (`D_bjump`), an absolute `j`/`jal` target, or a `jr`/`jalr` register target. It sits between the hazard unit (stall) and the D-stage decode/compare logic, and drives the instruction-memory address and the F/D pipeline register.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `TEXT_LO`, 32'h0000_3000, lowest legal fetch address (used only with the check feature).
- `TEXT_HI`, 32'h0000_6FFC, highest legal fetch address, inclusive (used only with the check feature).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `F_stall`  in  1  from hazard unit; 1 = hold PC this cycle.
- `D_NPCOp`  in  2  next-PC select for the instruction in D: 0 = PC4, 1 = BRANCH, 2 = J, 3 = JR.
- `D_bjump`  in  1  branch-taken flag from the D-stage comparator.
- `D_PC`  in  32  PC of the instruction currently in D.
- `D_imm16`  in  16  branch offset field.
- `D_imm26`  in  26  jump index field.
- `D_rs_data`  in  32  forwarded rs value, used for JR.
- `F_PC`  out  32  current fetch address (registered).
- `F_NPC`  out  32  combinational next PC.
- `F_exc_adel`  out  1  fetch address error (see Configuration).

## Operation
- `F_NPC` selection, evaluated combinationally every cycle:
  - PC4: `F_PC + 4`.
  - BRANCH with `D_bjump`=1: `D_PC + 4 + (sign_extend(D_imm16) << 2)`.
  - BRANCH with `D_bjump`=0: `F_PC + 4`.
  - J: `{D_PC[31:28], D_imm26, 2'b00}`.
  - JR: `D_rs_data`, passed unmodified (no alignment masking).
- All additions are 32-bit modulo 2^32. `F_PC`=FFFF_FFFC with PC4 gives `F_NPC`=0000_0000. A negative offset wraps the same way.
- Delay-slot semantics: when a redirect is decided in D, the instruction already in F (the delay slot) is not squashed. The redirect takes effect on the following fetch.
- `D_bjump` is ignored unless `D_NPCOp`=BRANCH.
- Register state: the PC register only. There is no pending-redirect buffer. The hazard unit freezes D whenever it freezes F, so D-stage redirect inputs stay stable for the whole stall.

## Timing
- Reset, asserted at any time including mid-stall: `F_PC` becomes `RESET_PC` immediately, without waiting for `clk`. `F_exc_adel` becomes 0.
- Reset release: the first rising edge with `reset`=1 and `F_stall`=0 loads `F_NPC`.
- Each rising edge: `F_PC` <= `F_NPC` when `F_stall`=0; `F_PC` is held when `F_stall`=1.
- Latency: a redirect present in D at edge N appears on `F_PC` after edge N, i.e. exactly one cycle.
- Stall and redirect in the same cycle: the stall wins and the PC holds. The redirect is applied on the first non-stalled edge, because the D inputs are unchanged.
- Undefined `D_NPCOp` values cannot occur with a 2-bit field, so there is no default hazard.

## Configuration
- Macro `FPC_ADEL_CHECK_EN`.
- Defined: `F_exc_adel` = (`F_PC[1:0]` != 0) OR (`F_PC` < `TEXT_LO`) OR (`F_PC` > `TEXT_HI`). This is combinational from the registered PC. Fetch continues regardless; squashing is the exception logic's job.
- Not defined: `F_exc_adel` is tied to 0 and the comparators are not synthesized.

## Test plan
- Reset: drive `reset`=0 mid-cycle while `F_PC`=0000_3010 -> `F_PC`=0000_3000 before the next edge. After release with PC4 for 3 edges -> 3004, 3008, 300C.
- Taken backward branch: `D_PC`=0000_3008, BRANCH, `D_bjump`=1, `D_imm16`=FFFE -> `F_PC`=0000_3004 after one edge. With `D_bjump`=0 -> `F_PC+4`.
- Jump and JR: `D_PC`=0000_3010, J, `D_imm26`=0000C40 -> 0000_3100. JR with `D_rs_data`=0000_3204 -> 0000_3204.
- Stall vs redirect: `F_stall`=1 for 2 cycles with a taken branch targeting 0000_3040 held in D -> PC frozen. It loads 0000_3040 on the first edge with `F_stall`=0.
- Wrap: force `F_PC`=FFFF_FFFC via JR, then PC4 -> 0000_0000.
- With `FPC_ADEL_CHECK_EN`: JR to 0000_3002 -> `F_exc_adel`=1. JR to 0000_7000 -> 1. JR to 0000_6FFC -> 0. Without the macro, all three cases -> 0.
